// File: rtl/conv1_window_gen.sv
// Sliding 3x3 window generator: buffers two padded RGB rows and emits one
// 3x3 window per channel for each accepted pixel with row >= 2 and col >= 2.
module conv1_window_gen #(
  parameter int QUAN_BITS = 8,
  parameter int IMG_W     = 34,
  parameter int IMG_H     = 34
) (
  input  logic                   s_clk,
  input  logic                   s_rst,
  input  logic                   i_clear,
  input  logic [QUAN_BITS-1:0]   i_feature_data_ch0,
  input  logic [QUAN_BITS-1:0]   i_feature_data_ch1,
  input  logic [QUAN_BITS-1:0]   i_feature_data_ch2,
  input  logic                   i_f_data_valid,
  output logic                   o_data_ready,
  output logic [9*QUAN_BITS-1:0] o_window_ch0,
  output logic [9*QUAN_BITS-1:0] o_window_ch1,
  output logic [9*QUAN_BITS-1:0] o_window_ch2,
  output logic                   o_window_valid,
  input  logic                   i_window_ready,
  output logic                   o_frame_done
);
  localparam int PW   = 3 * QUAN_BITS;
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int NWIN = (IMG_W - 2) * (IMG_H - 2);
  localparam int WW   = $clog2(NWIN + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(NWIN - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          accept, emit, handshake;
  logic [PW-1:0] pix, top, mid;
  logic [PW-1:0] lb_a_q [IMG_W];
  logic [PW-1:0] lb_b_q [IMG_W];

  assign o_data_ready = !win_valid_q || i_window_ready;
  assign accept       = i_f_data_valid && o_data_ready && !i_clear;
  assign handshake    = win_valid_q && i_window_ready;
  assign emit         = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign pix          = {i_feature_data_ch2, i_feature_data_ch1, i_feature_data_ch0};
  assign top          = lb_a_q[col_q];
  assign mid          = lb_b_q[col_q];

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // A new emitting accept wins over the handshake so back-to-back windows keep valid high.
  always_comb begin
    win_cnt_d    = win_cnt_q;
    frame_done_d = 1'b0;
    if (handshake) begin
      if (win_cnt_q == WIN_LAST) begin
        win_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        win_cnt_d = win_cnt_q + WW'(1);
      end
    end
    win_valid_d = emit ? 1'b1 : (handshake ? 1'b0 : win_valid_q);
  end

  always_ff @(posedge s_clk) begin
    if (s_rst || i_clear) begin
      col_q        <= '0;
      row_q        <= '0;
      win_cnt_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_cnt_q    <= win_cnt_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers are read combinationally above, so this write is read-before-write.
  always_ff @(posedge s_clk) begin
    if (accept) begin
      lb_a_q[col_q] <= lb_b_q[col_q];
      lb_b_q[col_q] <= pix;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    logic [9*QUAN_BITS-1:0] win_q;
    always_ff @(posedge s_clk) begin
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win_q[(r*3)*QUAN_BITS +: QUAN_BITS]   <= win_q[(r*3+1)*QUAN_BITS +: QUAN_BITS];
          win_q[(r*3+1)*QUAN_BITS +: QUAN_BITS] <= win_q[(r*3+2)*QUAN_BITS +: QUAN_BITS];
        end
        win_q[2*QUAN_BITS +: QUAN_BITS] <= top[gi*QUAN_BITS +: QUAN_BITS];
        win_q[5*QUAN_BITS +: QUAN_BITS] <= mid[gi*QUAN_BITS +: QUAN_BITS];
        win_q[8*QUAN_BITS +: QUAN_BITS] <= pix[gi*QUAN_BITS +: QUAN_BITS];
      end
    end
  end

  assign o_window_ch0   = g_ch[0].win_q;
  assign o_window_ch1   = g_ch[1].win_q;
  assign o_window_ch2   = g_ch[2].win_q;
  assign o_window_valid = win_valid_q;
  assign o_frame_done   = frame_done_q;
endmodule

// File: tb/tb_conv1_window_gen.sv
// Bench for conv1_window_gen: a 5x4 instance driven by directed scenarios and
// a 34x34 instance driven by random pixels against a window reference model.
module tb_conv1_window_gen;
  localparam int SW = 5, SH = 4;
  localparam int LW = 34, LH = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // small instance
  logic        s_clear, s_valid, s_rdy, s_wvalid, s_wready, s_fd;
  logic [7:0]  s_d0, s_d1, s_d2;
  logic [71:0] s_w0, s_w1, s_w2;
  // large instance
  logic        l_clear, l_valid, l_rdy, l_wvalid, l_wready, l_fd;
  logic [7:0]  l_d0, l_d1, l_d2;
  logic [71:0] l_w0, l_w1, l_w2;

  conv1_window_gen #(.QUAN_BITS(8), .IMG_W(SW), .IMG_H(SH)) dut_s (
    .s_clk(clk), .s_rst(rst), .i_clear(s_clear),
    .i_feature_data_ch0(s_d0), .i_feature_data_ch1(s_d1), .i_feature_data_ch2(s_d2),
    .i_f_data_valid(s_valid), .o_data_ready(s_rdy),
    .o_window_ch0(s_w0), .o_window_ch1(s_w1), .o_window_ch2(s_w2),
    .o_window_valid(s_wvalid), .i_window_ready(s_wready), .o_frame_done(s_fd));

  conv1_window_gen #(.QUAN_BITS(8), .IMG_W(LW), .IMG_H(LH)) dut_l (
    .s_clk(clk), .s_rst(rst), .i_clear(l_clear),
    .i_feature_data_ch0(l_d0), .i_feature_data_ch1(l_d1), .i_feature_data_ch2(l_d2),
    .i_f_data_valid(l_valid), .o_data_ready(l_rdy),
    .o_window_ch0(l_w0), .o_window_ch1(l_w1), .o_window_ch2(l_w2),
    .o_window_valid(l_wvalid), .i_window_ready(l_wready), .o_frame_done(l_fd));

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected windows of the 5x4 test image (pixel = row*5+col), bottom-right pixel (r,c).
  typedef struct {
    int          r;
    int          c;
    logic [71:0] e0;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [71:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    pk = {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic logic [71:0] addb(input logic [71:0] w, input int off);
    logic [71:0] res;
    for (int k = 0; k < 9; k++) res[k*8 +: 8] = w[k*8 +: 8] + 8'(off);
    return res;
  endfunction

  // small-instance monitor: every handshake and frame_done pulse is logged
  logic [71:0] cap0[$], cap1[$], cap2[$];
  int cap_cyc[$], fd_cyc[$];
  always @(negedge clk) begin
    if (s_wvalid && s_wready) begin
      cap0.push_back(s_w0); cap1.push_back(s_w1); cap2.push_back(s_w2);
      cap_cyc.push_back(cyc);
    end
    if (s_fd) fd_cyc.push_back(cyc);
  end

  task automatic clear_caps();
    cap0.delete(); cap1.delete(); cap2.delete(); cap_cyc.delete(); fd_cyc.delete();
  endtask

  task automatic drive_s(input int v);
    int g;
    g = 0;
    s_valid = 1'b1; s_d0 = 8'(v); s_d1 = 8'(v + 64); s_d2 = 8'(v + 128);
    @(negedge clk);
    while (!s_rdy && g < 200) begin @(negedge clk); g++; end
    if (!s_rdy) begin tests++; fails++; $display("FAIL drive_s_timeout: pixel %0d never accepted", v); end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_frame_s();
    for (int i = 0; i < SW*SH; i++) drive_s(i);
  endtask

  task automatic drain();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input int base, input string tag);
    for (int i = 0; i < 6; i++) begin
      if (base + i < cap0.size()) begin
        chk($sformatf("%s_ch0_r%0dc%0d", tag, tbl[i].r, tbl[i].c), cap0[base+i], tbl[i].e0);
        chk($sformatf("%s_ch1_r%0dc%0d", tag, tbl[i].r, tbl[i].c), cap1[base+i], addb(tbl[i].e0, 64));
        chk($sformatf("%s_ch2_r%0dc%0d", tag, tbl[i].r, tbl[i].c), cap2[base+i], addb(tbl[i].e0, 128));
      end else begin
        tests++; fails++;
        $display("FAIL %s_missing: window %0d not seen, required present", tag, i);
      end
    end
  endtask

  // large-instance reference model and monitor
  logic [23:0] l_img [LH][LW];
  logic [71:0] lexp0[$], lexp1[$], lexp2[$];
  int l_n = 0, l_fd_n = 0;
  logic [23:0] lc;
  always @(negedge clk) begin
    if (l_wvalid && l_wready) begin
      if (lexp0.size() == 0) begin
        tests++; fails++;
        $display("FAIL l_extra: window %0d beyond expected count", l_n);
      end else begin
        lc = l_img[l_n/(LW-2) + 1][l_n%(LW-2) + 1];
        chk($sformatf("l_centre_%0d", l_n), {64'd0, l_w0[4*8 +: 8]}, {64'd0, lc[7:0]});
        chk($sformatf("l_win_%0d", l_n), l_w0 ^ l_w1 ^ l_w2,
            lexp0.pop_front() ^ lexp1.pop_front() ^ lexp2.pop_front());
        l_n++;
      end
    end
    if (l_fd) l_fd_n++;
  end

  task automatic drive_l(input logic [23:0] v);
    int g;
    g = 0;
    l_valid = 1'b1; {l_d2, l_d1, l_d0} = v;
    @(negedge clk);
    while (!l_rdy && g < 200) begin @(negedge clk); g++; end
    if (!l_rdy) begin tests++; fails++; $display("FAIL drive_l_timeout: beat never accepted"); end
    @(posedge clk); #1;
    l_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  logic [71:0] ew0, ew1, ew2, snap;
  logic [23:0] px;
  int g, l_run;

  initial begin
    tbl[0] = '{r:2, c:2, e0:pk(0, 1, 2, 5, 6, 7, 10, 11, 12)};
    tbl[1] = '{r:2, c:3, e0:pk(1, 2, 3, 6, 7, 8, 11, 12, 13)};
    tbl[2] = '{r:2, c:4, e0:pk(2, 3, 4, 7, 8, 9, 12, 13, 14)};
    tbl[3] = '{r:3, c:2, e0:pk(5, 6, 7, 10, 11, 12, 15, 16, 17)};
    tbl[4] = '{r:3, c:3, e0:pk(6, 7, 8, 11, 12, 13, 16, 17, 18)};
    tbl[5] = '{r:3, c:4, e0:pk(7, 8, 9, 12, 13, 14, 17, 18, 19)};

    rst = 1'b1;
    s_clear = 0; s_valid = 0; s_d0 = 0; s_d1 = 0; s_d2 = 0; s_wready = 1;
    l_clear = 0; l_valid = 0; l_d0 = 0; l_d1 = 0; l_d2 = 0; l_wready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_s_wvalid", s_wvalid, 0); chk("rst_s_fd", s_fd, 0); chk("rst_s_ready", s_rdy, 1);
    chk("rst_l_wvalid", l_wvalid, 0); chk("rst_l_fd", l_fd, 0); chk("rst_l_ready", l_rdy, 1);
    @(posedge clk); #1;

    // 1: stream with no backpressure
    clear_caps();
    send_frame_s();
    drain();
    chk("s1_nwin", cap0.size(), 6);
    check_frame(0, "s1");
    chk("s1_nfd", fd_cyc.size(), 1);
    if (cap_cyc.size() == 6 && fd_cyc.size() >= 1) begin
      chk("s1_fd_time", fd_cyc[0], cap_cyc[5] + 1);
      chk("s1_back2back", cap_cyc[1], cap_cyc[0] + 1);
    end

    // 2: backpressure while a window is pending
    clear_caps();
    fork
      send_frame_s();
      begin
        g = 0;
        @(posedge clk); #1;
        while (!s_wvalid && g < 200) begin @(posedge clk); #1; g++; end
        chk("s2_pending_seen", s_wvalid, 1);
        snap = s_w0;
        s_wready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("s2_ready_low", s_rdy, 0);
          chk("s2_hold_valid", s_wvalid, 1);
          chk("s2_hold_data", s_w0, snap);
        end
        @(posedge clk); #1;
        s_wready = 1'b1;
      end
    join
    drain();
    chk("s2_nwin", cap0.size(), 6);
    check_frame(0, "s2");
    chk("s2_nfd", fd_cyc.size(), 1);

    // 3: throttled input, valid every other cycle
    clear_caps();
    for (int i = 0; i < SW*SH; i++) begin
      drive_s(i);
      @(negedge clk);
      if (i == 11) chk("s3_no_win_before", s_wvalid, 0);
      if (i == 12) chk("s3_latency", s_wvalid, 1);
      if (i == 15 || i == 16) chk($sformatf("s3_rowedge_%0d", i), s_wvalid, 0);
      @(posedge clk); #1;
      if (i == 12) chk("s3_fall", s_wvalid, 0);
    end
    drain();
    chk("s3_nwin", cap0.size(), 6);
    check_frame(0, "s3");

    // 5: abort with a dropped beat, then abort with a pending window, then a clean frame
    clear_caps();
    for (int i = 0; i < 9; i++) drive_s(i);
    s_valid = 1'b1; s_d0 = 8'd9; s_d1 = 8'd73; s_d2 = 8'd137; s_clear = 1'b1;
    @(posedge clk); #1;
    s_clear = 1'b0; s_valid = 1'b0;
    s_wready = 1'b0;
    for (int i = 0; i < 13; i++) drive_s(i);
    @(negedge clk);
    chk("s5_pending", s_wvalid, 1);
    @(posedge clk); #1;
    s_clear = 1'b1;
    @(posedge clk); #1;
    s_clear = 1'b0;
    @(negedge clk);
    chk("s5_killed", s_wvalid, 0);
    chk("s5_ready", s_rdy, 1);
    @(posedge clk); #1;
    s_wready = 1'b1;
    send_frame_s();
    drain();
    chk("s5_nwin", cap0.size(), 6);
    check_frame(0, "s5");
    chk("s5_nfd", fd_cyc.size(), 1);

    // 6: two frames back to back
    clear_caps();
    send_frame_s();
    send_frame_s();
    drain();
    chk("s6_nwin", cap0.size(), 12);
    check_frame(0, "s6a");
    check_frame(6, "s6b");
    chk("s6_nfd", fd_cyc.size(), 2);

    // 4: default size, random pixels, random window ready
    for (int r = 0; r < LH; r++)
      for (int c = 0; c < LW; c++) l_img[r][c] = 24'($urandom);
    for (int r = 2; r < LH; r++)
      for (int c = 2; c < LW; c++) begin
        for (int k = 0; k < 9; k++) begin
          px = l_img[r - 2 + k/3][c - 2 + k%3];
          ew0[k*8 +: 8] = px[7:0];
          ew1[k*8 +: 8] = px[15:8];
          ew2[k*8 +: 8] = px[23:16];
        end
        lexp0.push_back(ew0); lexp1.push_back(ew1); lexp2.push_back(ew2);
      end
    l_run = 1;
    fork
      begin
        for (int r = 0; r < LH; r++)
          for (int c = 0; c < LW; c++) drive_l(l_img[r][c]);
        g = 0;
        while (l_n < (LW-2)*(LH-2) && g < 5000) begin @(posedge clk); g++; end
        repeat (3) @(posedge clk);
        l_run = 0;
      end
      begin
        while (l_run != 0) begin
          @(posedge clk); #1;
          l_wready = ($urandom_range(0, 3) != 0);
        end
        l_wready = 1'b1;
      end
    join
    drain();
    chk("l_nwin", l_n, (LW-2)*(LH-2));
    chk("l_nfd", l_fd_n, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
